alu_rr_arbiter: RTL
===================

Name: alu_rr_arbiter

Overview:
- Shares a single ALU between NREQ independent requesters using round-robin arbitration.
- Each requester has a valid/ready request channel and a valid/ready response channel.
- The block registers the granted operands, drives the shared ALU, captures result and zero flag, and returns them to the winning requester.
- Sits between the multi-cycle datapath clients and the single ALU instance.

Parameters:
- NREQ, 2, number of requesters (2..8).
- W, 32, operand/result width; must match the ALU width.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester request accept; at most one bit set.
- req_a  input  NREQ*W  operand A, packed; requester i at [i*W +: W].
- req_b  input  NREQ*W  operand B, packed.
- req_op  input  NREQ*3  ALU operation, packed; requester i at [i*3 +: 3].
- resp_valid  output  NREQ  one-hot response valid.
- resp_ready  input  NREQ  per-requester response accept.
- resp_data  output  W  result; shared by all requesters, qualified by resp_valid.
- resp_zero  output  1  zero flag captured with the result.
- resp_err  output  1  illegal-opcode flag (see Optional Feature).
- alu_a  output  W  to the shared ALU.
- alu_b  output  W  to the shared ALU.
- alu_op  output  3  to the shared ALU.
- alu_out  input  W  from the shared ALU (combinational).
- alu_zero  input  1  from the shared ALU.

Behaviour:
- ALU opcodes: 000 add, 001 sub, 010 and, 011 or, 101 unsigned set-less-than; any other code returns 0 and zero=1.
- FSM states IDLE, EXEC, RESP. Reset state is IDLE.
- Reset values:
  - rr_ptr=0, gnt_id=0.
  - alu_a, alu_b, alu_op, resp_data, resp_zero, resp_err = 0.
  - req_ready=0, resp_valid=0.
- Arbitration: combinational, evaluated only in IDLE.
  - Search req_valid starting at index rr_ptr, wrapping modulo NREQ.
  - The first set bit is the grant g.
  - req_ready = one-hot(g) when in IDLE and any valid is set; otherwise all zero.
- IDLE -> EXEC on handshake req_valid[g] & req_ready[g] (cycle T).
  - Register operands of g into alu_a, alu_b, alu_op; gnt_id <= g; rr_ptr <= (g+1) mod NREQ.
- EXEC (cycle T+1): ALU inputs are stable.
  - resp_data <= alu_out, resp_zero <= alu_zero; go to RESP.
- RESP (from cycle T+2): resp_valid = one-hot(gnt_id).
  - Hold resp_data, resp_zero and resp_err until resp_ready[gnt_id]=1, then return to IDLE.
  - resp_ready of non-granted requesters is ignored.
- Latency: request accept to resp_valid is 2 cycles.
- Throughput: at most one operation per 3 cycles. No request is accepted in EXEC or RESP, including the cycle the response is consumed.
- Requester contract: req_a, req_b, req_op need only be stable in the handshake cycle.
  - Dropping req_valid without a handshake is legal and loses nothing.
- Fairness: a requester that holds valid is granted within NREQ arbitration rounds.
- Single active requester: it is granted on every round regardless of rr_ptr.
- No valid requests: stay in IDLE, req_ready=0, rr_ptr unchanged.
- Reset asserted mid-operation: the in-flight transaction is discarded, all registers return to reset values, and no response is issued.

Optional Feature:
- Macro ALU_OPCHK_EN.
- Defined:
  - In IDLE, a granted op in {100,110,111} is still accepted.
  - EXEC is skipped: next state RESP directly, with resp_data=0, resp_zero=0, resp_err=1.
  - The ALU is not driven: alu_op and operands keep their previous values.
  - Latency for an illegal op is 1 cycle.
- Undefined: resp_err is tied 0 and every opcode passes through the ALU; the ALU returns 0 for illegal codes.

Test Plan:
- Reset, then req0: a=5, b=3, op=000 -> handshake at T; resp_valid=01 at T+2; resp_data=8, resp_zero=0; req_ready=00 during EXEC and RESP.
- Both requesters valid continuously: req0 7-7 op=001, req1 0xF0|0x0F op=011 -> grants alternate 0,1,0,1. First response 0 with zero=1, second 0xFF.
- Response backpressure: req1 op=101 with a=2, b=9, resp_ready held low for 5 cycles -> resp_valid and resp_data=1 stay stable; a pending req0 is not accepted until the cycle after resp_ready=1.
- NREQ=4, only req2 valid, rr_ptr=3 -> req2 granted (wrap-around); rr_ptr becomes 3.
- rst_n pulsed low during EXEC -> all outputs 0 immediately (asynchronous); no resp_valid afterwards; the next request completes normally.
- ALU_OPCHK_EN defined, op=111 -> resp_valid at T+1, resp_err=1, resp_data=0. Macro undefined: resp_valid at T+2, resp_err=0, resp_data=0, resp_zero=1.

Source files
------------

// File: rtl/alu_rr_arbiter.sv
// Purpose: round-robin sharing of one ALU between NREQ requesters (optional macro ALU_OPCHK_EN).
// Latency: request accept to resp_valid is 2 cycles (1 cycle for a rejected opcode with ALU_OPCHK_EN).
// Backpressure: result held in RESP until the granted requester's resp_ready; no accepts until back in IDLE.
module alu_rr_arbiter #(
  parameter int NREQ = 2,
  parameter int W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ*3-1:0] req_op,
  output logic [NREQ-1:0]   resp_valid,
  input  logic [NREQ-1:0]   resp_ready,
  output logic [W-1:0]      resp_data,
  output logic              resp_zero,
  output logic              resp_err,
  output logic [W-1:0]      alu_a,
  output logic [W-1:0]      alu_b,
  output logic [2:0]        alu_op,
  input  logic [W-1:0]      alu_out,
  input  logic              alu_zero
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] gnt_id;
  logic [IW-1:0] grant;
  logic          any_vld;
  logic          hs;

  // Unpacked views of the packed per-requester operand buses
  logic [W-1:0] a_arr  [NREQ];
  logic [W-1:0] b_arr  [NREQ];
  logic [2:0]   op_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign a_arr[i]  = req_a[i*W +: W];
    assign b_arr[i]  = req_b[i*W +: W];
    assign op_arr[i] = req_op[i*3 +: 3];
  end

`ifdef ALU_OPCHK_EN
  logic grant_illegal;
  logic resp_err_q;
  // Codes 100, 110 and 111 have no ALU meaning and bypass execution
  assign grant_illegal = (op_arr[grant] == 3'b100) || (op_arr[grant][2:1] == 2'b11);
  assign resp_err      = resp_err_q;
`else
  assign resp_err = 1'b0;
`endif

  // Round-robin search: first valid at or after rr_ptr, wrapping; lowest offset wins
  always_comb begin
    logic [IW:0] cand;
    any_vld = 1'b0;
    grant   = '0;
    cand    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(NREQ)) cand = cand - (IW+1)'(NREQ);
      if (req_valid[cand[IW-1:0]]) begin
        grant   = cand[IW-1:0];
        any_vld = 1'b1;
      end
    end
  end

  assign hs = |(req_valid & req_ready);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (hs) begin
`ifdef ALU_OPCHK_EN
          state_nxt = grant_illegal ? RESP : EXEC;
`else
          state_nxt = EXEC;
`endif
        end
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (resp_ready[gnt_id]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs; req_ready is also forced low while reset is asserted
  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    if (state == IDLE && any_vld && rst_n) req_ready = ONE << grant;
    if (state == RESP) resp_valid = ONE << gnt_id;
  end

  // Datapath: capture operands on accept, capture ALU result in EXEC, hold through RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      gnt_id     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      resp_data  <= '0;
      resp_zero  <= 1'b0;
`ifdef ALU_OPCHK_EN
      resp_err_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (hs) begin
            gnt_id <= grant;
            rr_ptr <= (grant == IW'(NREQ - 1)) ? '0 : grant + 1'b1;
`ifdef ALU_OPCHK_EN
            if (grant_illegal) begin
              // ALU inputs left untouched; the error response is formed here
              resp_data  <= '0;
              resp_zero  <= 1'b0;
              resp_err_q <= 1'b1;
            end else begin
              alu_a      <= a_arr[grant];
              alu_b      <= b_arr[grant];
              alu_op     <= op_arr[grant];
              resp_err_q <= 1'b0;
            end
`else
            alu_a  <= a_arr[grant];
            alu_b  <= b_arr[grant];
            alu_op <= op_arr[grant];
`endif
          end
        end
        EXEC: begin
          resp_data <= alu_out;
          resp_zero <= alu_zero;
        end
        default: ;
      endcase
    end
  end

endmodule
